code842_serializer: RTL
=======================

# code842_serializer

Downstream stage of the BCD to 8-4-(-2)-(-1) code converter. It accepts one 4-bit coded digit per valid/ready handshake and checks it against the ten legal codewords. Legal digits go out as a framed serial bit stream: start, 4 data bits MSB first, even parity, stop. Illegal digits are dropped, flagged and counted.

## Interface
- CLKS_PER_BIT, default 4: clock cycles per serial bit; legal range 1..255.
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_code  input  4  coded digit from the converter (o[3:0] weighting 8,4,-2,-1).
- in_valid  input  1  in_code valid this cycle.
- in_ready  output  1  block can accept a digit this cycle.
- tx  output  1  serial line, idle high.
- busy  output  1  a frame is in progress.
- err  output  1  one-cycle pulse when an illegal code is accepted.
- err_cnt  output  8  saturating count of illegal codes.

## Operation
- Legal codes are 0000, 0111, 0110, 0101, 0100, 1011, 1010, 1001, 1000 and 1111 (digits 0..9). Illegal codes are 0001, 0010, 0011, 1100, 1101 and 1110.
- Legal-code mask is 16'h8FF1; in_code indexes it.
- Accept: in_valid & in_ready at a rising edge.
- in_ready = (state == IDLE). It is registered-state derived and has no combinational path from in_valid.
- On accept of a legal code:
  - latch shift register = in_code, parity = ^in_code;
  - go to START.
- On accept of an illegal code:
  - stay in IDLE; tx stays 1;
  - err = 1 for the next cycle only;
  - err_cnt increments, holding at 255.
- FSM states: IDLE → START → DATA (4 bits, bit index 3 down to 0) → PARITY → STOP → IDLE.
- Each non-IDLE state holds for exactly CLKS_PER_BIT cycles, paced by the bit timer.
- tx value per state:
  - IDLE: 1;
  - START: 0;
  - DATA: current bit;
  - PARITY: even parity bit (XOR of the 4 data bits);
  - STOP: 1.
- busy = (state != IDLE).
- in_valid while busy is ignored; the source holds in_code stable until accepted.

## Timing
- Reset values (asynchronous, immediate): state = IDLE, tx = 1, busy = 0, in_ready = 1, err = 0, err_cnt = 0, shift register = 0, bit timer = 0.
- Accept at edge t: START drives tx = 0 from t through t+C, where C = CLKS_PER_BIT.
- Frame length is 7·C cycles. STOP's last cycle ends at edge t+7C; IDLE with in_ready = 1 follows.
- Back-to-back frames: the earliest next accept is edge t+7C+1. This gives a minimum 1-cycle idle-high gap plus the stop bit.
- err asserts in the cycle after the illegal accept and clears the cycle after that. Two consecutive illegal accepts produce a 2-cycle-high err and +2 on err_cnt.
- At err_cnt = 255, further illegal codes still pulse err; the count does not wrap.
- Reset mid-frame aborts immediately: tx = 1 and the frame is lost. Nothing is retransmitted after reset.
- With C = 1, one bit is sent per cycle; the bit timer is bypassed or counts 0..0.

## Structure
- Shared package code842_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - LEGAL_MASK = 16'h8FF1;
  - DATA_BITS = 4.
- Sub-module code842_bit_timer:
  - counts 0..CLKS_PER_BIT-1 while enabled;
  - emits a one-cycle bit_done on the last count;
  - clears when disabled.
- Top level holds the FSM, the shift register, the parity register and the error counter.

## Test plan
- Reset, then in_code = 0111 held valid, C = 4: accepted at the first edge. tx sampled every 4 cycles reads 0, 0,1,1,1, 1, 1. busy is high for 28 cycles and in_ready returns on cycle 29.
- in_code = 0000, then 1111 back-to-back: tx reads 0,0000,0,1 for the first frame and 0,1111,0,1 for the second. Exactly one idle-high cycle separates the frames.
- in_code = 0011: accepted, err high for exactly 1 cycle, err_cnt = 1, tx constant 1, busy never set. in_ready is high the next cycle.
- 300 consecutive illegal codes (1100): err_cnt reaches 255 and stays there; err pulses on every accept.
- Assert rst during the DATA bit 1 of digit 1011: tx = 1 and in_ready = 1 immediately, without waiting for a clock edge. After release, a new digit 0100 is sent cleanly (0,0100,1,1).
- in_valid toggled with changing codes while busy: no accept occurs until IDLE, and the frame in flight is unaltered.

Source files
------------

// File: rtl/code842_pkg.sv
// -----------------------------------------------------------------------------
// code842_pkg
// Shared definitions for the 8-4-(-2)-(-1) code serializer: FSM state type,
// legal-codeword mask and data width, plus a small legality helper.
// -----------------------------------------------------------------------------
package code842_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Bit n set means codeword n is one of the ten legal digits.
    localparam logic [15:0] LEGAL_MASK = 16'h8FF1;
    localparam int          DATA_BITS  = 4;

    function automatic logic is_legal(input logic [DATA_BITS-1:0] code);
        return LEGAL_MASK[code];
    endfunction

endpackage

// File: rtl/code842_serializer_if.sv
// -----------------------------------------------------------------------------
// code842_serializer_if
// Valid/ready handshake carrying one coded digit from the converter.
//   in_code  : coded digit (weights 8,4,-2,-1), source -> serializer
//   in_valid : in_code is valid this cycle,   source -> serializer
//   in_ready : serializer can accept a digit, serializer -> source
// Modports: master = digit source, slave = serializer.
// -----------------------------------------------------------------------------
interface code842_serializer_if;
    import code842_pkg::*;

    logic [DATA_BITS-1:0] in_code;
    logic                 in_valid;
    logic                 in_ready;

    modport master (output in_code, output in_valid, input  in_ready);
    modport slave  (input  in_code, input  in_valid, output in_ready);

endinterface

// File: rtl/code842_bit_timer.sv
// -----------------------------------------------------------------------------
// code842_bit_timer
// Paces the serial bit period. Counts 0..CLKS_PER_BIT-1 while enabled and
// raises bit_done for one cycle on the last count; held at 0 when disabled.
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   en       : count enable (a frame is in progress)
//   bit_done : last cycle of the current bit period
// -----------------------------------------------------------------------------
module code842_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic bit_done
);

    localparam logic [7:0] LAST_COUNT = 8'(CLKS_PER_BIT - 1);

    logic [7:0] count;

    // With CLKS_PER_BIT = 1 the count never leaves 0 and bit_done follows en.
    assign bit_done = en && (count == LAST_COUNT);

    // NOTE: sequential state uses non-blocking assignments and an asynchronous
    // reset in the sensitivity list, so every flop clears without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!en || bit_done) begin
            count <= '0;
        end else begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/code842_serializer.sv
// -----------------------------------------------------------------------------
// code842_serializer
// Accepts one coded digit per handshake. Legal digits are sent on tx as
// start(0), 4 data bits MSB first, even parity, stop(1), each bit lasting
// CLKS_PER_BIT cycles. Illegal digits are dropped, pulse err and bump a
// saturating counter.
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   bus     : digit handshake (slave side)
//   tx      : serial line, idle high
//   busy    : a frame is in progress
//   err     : one-cycle pulse after an illegal digit is accepted
//   err_cnt : saturating count of illegal digits
// -----------------------------------------------------------------------------
module code842_serializer
    import code842_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    code842_serializer_if.slave  bus,
    output logic                 tx,
    output logic                 busy,
    output logic                 err,
    output logic [7:0]           err_cnt
);

    localparam logic [1:0] LAST_IDX = 2'(DATA_BITS - 1);

    state_t               state, state_next;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity;
    logic [1:0]           bit_idx;
    logic                 bit_done;
    logic                 accept;
    logic                 legal;

    // Ready depends on registered state only, never on in_valid.
    assign bus.in_ready = (state == IDLE);
    assign busy         = (state != IDLE);
    assign accept       = bus.in_valid && bus.in_ready;
    assign legal        = is_legal(bus.in_code);

    code842_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .en       (busy),
        .bit_done (bit_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        tx         = 1'b1;
        unique case (state)
            IDLE: begin
                if (accept && legal) state_next = START;
            end
            START: begin
                tx = 1'b0;
                if (bit_done) state_next = DATA;
            end
            DATA: begin
                tx = shift_reg[DATA_BITS-1];
                if (bit_done && bit_idx == 2'd0) state_next = PARITY;
            end
            PARITY: begin
                tx = parity;
                if (bit_done) state_next = STOP;
            end
            STOP: begin
                if (bit_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Data path: load on a legal accept, shift MSB-first at each DATA bit end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            parity    <= 1'b0;
            bit_idx   <= '0;
        end else if (state == IDLE) begin
            if (accept && legal) begin
                shift_reg <= bus.in_code;
                parity    <= ^bus.in_code;
                bit_idx   <= LAST_IDX;
            end
        end else if (state == DATA && bit_done) begin
            shift_reg <= {shift_reg[DATA_BITS-2:0], 1'b0};
            bit_idx   <= bit_idx - 2'd1;
        end
    end

    // Error flag and saturating error counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            err <= accept && !legal;
            if (accept && !legal && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule
